// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, inverse MixColumns coefficients and control FSM states.
// Column access helpers treat a state as four 32-bit rows with column 0 in bits [31:24].
package aes_pkg;

  localparam logic [7:0] AES_RED = 8'h1b;
  localparam logic [7:0] INV_C0  = 8'h0e;
  localparam logic [7:0] INV_C1  = 8'h0b;
  localparam logic [7:0] INV_C2  = 8'h0d;
  localparam logic [7:0] INV_C3  = 8'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row 0 sits at index 0 so that {line0, line1, line2, line3} packs naturally.
  typedef logic [0:3][31:0] mat_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] get_col(input mat_t m, input logic [1:0] c);
    logic [31:0] col;
    col = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      col[31 - 8*r -: 8] = m[r][31 - 8*int'(c) -: 8];
    end
    return col;
  endfunction

  function automatic mat_t put_col(input mat_t m, input logic [1:0] c, input logic [31:0] col);
    mat_t res;
    res = m;
    for (int r = 0; r < 4; r++) begin
      res[r][31 - 8*int'(c) -: 8] = col[31 - 8*r -: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// Combinational inverse MixColumns of one 32-bit column (row 0 byte in [31:24]).
module inv_mix_col_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Circulant rows: {0e,0b,0d,09} rotated right by the row index.
  assign mixed[31:24] = gmul(a0, INV_C0) ^ gmul(a1, INV_C1) ^ gmul(a2, INV_C2) ^ gmul(a3, INV_C3);
  assign mixed[23:16] = gmul(a0, INV_C3) ^ gmul(a1, INV_C0) ^ gmul(a2, INV_C1) ^ gmul(a3, INV_C2);
  assign mixed[15:8]  = gmul(a0, INV_C2) ^ gmul(a1, INV_C3) ^ gmul(a2, INV_C0) ^ gmul(a3, INV_C1);
  assign mixed[7:0]   = gmul(a0, INV_C1) ^ gmul(a1, INV_C2) ^ gmul(a2, INV_C3) ^ gmul(a3, INV_C0);

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns with valid/ready handshake; one column per cycle by default.
// Define INV_MIX_FAST_EN to transform all four columns in a single BUSY cycle.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line0,
  input  logic [31:0] line1,
  input  logic [31:0] line2,
  input  logic [31:0] line3,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] outline0,
  output logic [31:0] outline1,
  output logic [31:0] outline2,
  output logic [31:0] outline3,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t     state, state_nxt;
  logic [1:0] col_cnt, col_cnt_nxt;
  mat_t       work, work_nxt;
  logic       in_ready_nxt, out_valid_nxt;

`ifdef INV_MIX_FAST_EN
  logic [31:0] mixed [4];

  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_mix_col_word u_word (
      .col   (get_col(work, 2'(g))),
      .mixed (mixed[g])
    );
  end
`else
  logic [31:0] mixed;

  inv_mix_col_word u_word (
    .col   (get_col(work, col_cnt)),
    .mixed (mixed)
  );
`endif

  // Next-state, datapath update and handshake flags.
  always_comb begin
    state_nxt     = state;
    col_cnt_nxt   = col_cnt;
    work_nxt      = work;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_nxt     = {line0, line1, line2, line3};
          col_cnt_nxt  = 2'd0;
          in_ready_nxt = 1'b0;
          state_nxt    = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
`ifdef INV_MIX_FAST_EN
        for (int c = 0; c < 4; c++) begin
          work_nxt = put_col(work_nxt, 2'(c), mixed[c]);
        end
        col_cnt_nxt   = 2'd0;
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
`else
        work_nxt    = put_col(work, col_cnt, mixed);
        col_cnt_nxt = col_cnt + 2'd1;
        if (col_cnt == 2'd3) begin
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          state_nxt = BUSY;
        end
`endif
      end
      DONE: begin
        // in_ready rises only after the handshake edge, so no same-cycle re-accept.
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        col_cnt_nxt   = 2'd0;
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State, counter, working register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= 2'd0;
      work      <= 128'h0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_cnt   <= col_cnt_nxt;
      work      <= work_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  assign outline0 = work[0];
  assign outline1 = work[1];
  assign outline2 = work[2];
  assign outline3 = work[3];

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns against a matrix-arithmetic GF(2^8) model.
module tb_inv_mix_columns;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] line0 = 32'h0, line1 = 32'h0, line2 = 32'h0, line3 = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] outline0, outline1, outline2, outline3;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [127:0] got;

  int passed = 0;
  int total  = 0;

`ifdef INV_MIX_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  inv_mix_columns dut (
    .clk       (clk),
    .rst       (rst),
    .line0     (line0),
    .line1     (line1),
    .line2     (line2),
    .line3     (line3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outline0  (outline0),
    .outline1  (outline1),
    .outline2  (outline2),
    .outline3  (outline3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  assign got = {outline0, outline1, outline2, outline3};

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product; byte (r,c) lives in line r, byte c.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] row0);
    logic [127:0] res;
    logic [7:0]   k [4];
    logic [7:0]   acc;
    res = 128'h0;
    for (int j = 0; j < 4; j++) k[j] = row0[31 - 8*j -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(k[(j - r + 4) % 4], s[127 - 32*j - 8*c -: 8]);
        res[127 - 32*r - 8*c -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    return mix(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] s);
    return mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] s);
    {line0, line1, line2, line3} = s;
  endtask

  // Waits for in_ready, presents s for one accepting edge, then counts cycles to out_valid.
  task automatic accept(input logic [127:0] s, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      lat = -1;
      return;
    end
    drive(s);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drive(rnd128());
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (got !== 128'h0) $display("FAIL reset_outlines got=%h exp=0", got); else passed++;
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_col0_vector();
    int lat;
    logic [127:0] s;
    s = {32'h8e000000, 32'h4d000000, 32'ha1000000, 32'hbc000000};
    accept(s, lat);
    total++; if (lat !== LAT) $display("FAIL col0_latency got=%0d exp=%0d", lat, LAT); else passed++;
    total++; if (got !== {32'hdb000000, 32'h13000000, 32'h53000000, 32'h45000000})
      $display("FAIL col0_vector got=%h exp=db000000130000005300000045000000", got); else passed++;
    total++; if (got !== inv_ref(s)) $display("FAIL col0_model got=%h exp=%h", got, inv_ref(s)); else passed++;
    handshake();
    total++; if (out_valid !== 1'b0) $display("FAIL col0_release got=%b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL col0_ready_back got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_four_columns();
    int lat;
    logic [127:0] s;
    s = {32'h9fd501c6, 32'hdcd501c6, 32'h58d701c6, 32'h9dd601c6};
    accept(s, lat);
    total++; if (lat !== LAT) $display("FAIL cols_latency got=%0d exp=%0d", lat, LAT); else passed++;
    total++; if (got !== {32'hf2d401c6, 32'h0ad401c6, 32'h22d401c6, 32'h5cd501c6})
      $display("FAIL cols_vector got=%h exp=f2d401c60ad401c622d401c65cd501c6", got); else passed++;
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    logic [127:0] s;
    logic [127:0] exp;
    s = rnd128();
    exp = inv_ref(s);
    accept(s, lat);
    total++; if (lat !== LAT) $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT); else passed++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      drive(rnd128());
      step();
      total++; if (got !== exp) $display("FAIL hold_data cyc=%0d got=%h exp=%h", i, got, exp); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, out_valid); else passed++;
    end
    in_valid = 1'b1;
    handshake();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL hold_no_reaccept got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL hold_release got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [127:0] s;
    s = rnd128();
    drive(s);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    total++; if (got !== 128'h0) $display("FAIL midrst_outlines got=%h exp=0", got); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", in_ready); else passed++;
    step();
    rst = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_no_resume got=%b exp=0", out_valid); else passed++;
    s = rnd128();
    accept(s, lat);
    total++; if (lat !== LAT) $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); else passed++;
    total++; if (got !== inv_ref(s)) $display("FAIL midrst_result got=%h exp=%h", got, inv_ref(s)); else passed++;
    handshake();
  endtask

  // Even items: random state vs. model; odd items: forward-mixed state must come back unchanged.
  task automatic test_back_to_back();
    int lat;
    int k;
    logic took;
    logic [127:0] src;
    logic [127:0] exp;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 1) begin
        exp = rnd128();
        src = fwd_ref(exp);
      end else begin
        src = rnd128();
        exp = inv_ref(src);
      end
      accept(src, lat);
      total++; if (lat !== LAT) $display("FAIL b2b_latency item=%0d got=%0d exp=%0d", i, lat, LAT); else passed++;
      total++; if (got !== exp) $display("FAIL b2b_result item=%0d got=%h exp=%h", i, got, exp); else passed++;
      k = 0;
      do begin
        out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        took = out_ready;
        step();
        k++;
        if (!took) begin
          total++; if (got !== exp) $display("FAIL b2b_stable item=%0d got=%h exp=%h", i, got, exp); else passed++;
        end
      end while (!took);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_col0_vector();
    test_four_columns();
    test_hold();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
